// File: rtl/ksk_mgr_common_pkg.sv
// Shared KSK manager definitions: width formulas and FSM encoding.
// Each block recomputes its widths from its own parameters with these helpers.
package ksk_mgr_common;

    localparam int DFLT_SLOT_NB    = 4;
    localparam int DFLT_SLOT_DEPTH = 32;
    localparam int DFLT_CUT_NB     = 2;
    localparam int DFLT_PASS_W     = 4;

    function automatic int calc_w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int calc_slot_w(input int slot_nb);
        return calc_w(slot_nb);
    endfunction

    function automatic int calc_slot_add_w(input int slot_depth);
        return calc_w(slot_depth);
    endfunction

    function automatic int calc_ram_add_w(input int slot_nb,
                                          input int slot_depth);
        return calc_w(slot_nb * slot_depth);
    endfunction

    // node_cmd_t = {buf_in_avail, buf_shift, ram_rd_addD, ram_rd_enD}
    function automatic int calc_node_cmd_w(input int ram_add_w);
        return ram_add_w + 3;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } rd_state_e;

endpackage

// File: rtl/ksk_mgr_cmd_skew.sv
// Systolic skew of the node command: cut k sees cut 0 delayed by k cycles.
// Cut 0 passes straight through; each further cut adds one register.
module ksk_mgr_cmd_skew #(
    parameter int  KSK_CUT_NB = 2,
    parameter type node_cmd_t = logic [7:0]
) (
    input  logic      clk,
    input  logic      s_rst_n,
    input  node_cmd_t cmd_in,
    output node_cmd_t cmd_out [KSK_CUT_NB]
);

    assign cmd_out[0] = cmd_in;

    for (genvar k = 1; k < KSK_CUT_NB; k++) begin : g_stage
        node_cmd_t stage_q;

        always_ff @(posedge clk or negedge s_rst_n) begin
            if (!s_rst_n) begin
                stage_q <= '0;
            end else begin
                stage_q <= cmd_out[k-1];
            end
        end

        assign cmd_out[k] = stage_q;
    end

endmodule

// File: rtl/ksk_mgr_rd_cmd_gen.sv
// KSK RAM read command generator: walks a filled slot line by line for
// the requested number of passes, then releases the slot.
module ksk_mgr_rd_cmd_gen
    import ksk_mgr_common::*;
#(
    parameter int  KSK_SLOT_NB    = DFLT_SLOT_NB,
    parameter int  KSK_SLOT_DEPTH = DFLT_SLOT_DEPTH,
    parameter int  KSK_CUT_NB     = DFLT_CUT_NB,
    parameter int  PASS_W         = DFLT_PASS_W,
    localparam int KSK_SLOT_W     = calc_slot_w(KSK_SLOT_NB),
    localparam int KSK_SLOT_ADD_W = calc_slot_add_w(KSK_SLOT_DEPTH),
    localparam int KSK_RAM_ADD_W  = calc_ram_add_w(KSK_SLOT_NB, KSK_SLOT_DEPTH),
    localparam int NODE_CMD_W     = calc_node_cmd_w(KSK_RAM_ADD_W)
) (
    input  logic                           clk,
    input  logic                           s_rst_n,
    input  logic                           fill_done_vld,
    input  logic [KSK_SLOT_W-1:0]          fill_done_id,
    input  logic                           rd_req_vld,
    output logic                           rd_req_rdy,
    input  logic [KSK_SLOT_W-1:0]          rd_req_slot,
    input  logic [PASS_W-1:0]              rd_req_pass,
    input  logic                           buf_avail,
    output logic [KSK_CUT_NB*NODE_CMD_W-1:0] node_cmd,
    output logic                           slot_free_vld,
    output logic [KSK_SLOT_W-1:0]          slot_free_id,
    output logic [KSK_SLOT_NB-1:0]         slot_full,
    output logic                           err_refill
);

    typedef struct packed {
        logic                     buf_in_avail;
        logic                     buf_shift;
        logic [KSK_RAM_ADD_W-1:0] ram_rd_addD;
        logic                     ram_rd_enD;
    } node_cmd_t;

    localparam int SLOT_SPAN = 1 << KSK_SLOT_W;

    localparam logic [KSK_SLOT_ADD_W-1:0] LINE_ONE  = 1;
    localparam logic [KSK_SLOT_ADD_W-1:0] LINE_LAST =
        KSK_SLOT_ADD_W'(KSK_SLOT_DEPTH - 1);
    localparam logic [PASS_W:0]           PASS_ONE  = 1;
    localparam logic [KSK_SLOT_W:0]       SLOT_LIM  =
        (KSK_SLOT_W + 1)'(KSK_SLOT_NB);
    localparam logic [KSK_RAM_ADD_W-1:0]  DEPTH_A   =
        KSK_RAM_ADD_W'(KSK_SLOT_DEPTH);

    rd_state_e                 state_q;
    logic [KSK_SLOT_W-1:0]     slot_q;
    logic [PASS_W:0]           pass_nb_q;
    logic [PASS_W:0]           pass_q;
    logic [KSK_SLOT_ADD_W-1:0] line_q;
    logic [KSK_RAM_ADD_W-1:0]  base_q;
    logic                      free_q;

    logic [SLOT_SPAN-1:0]      full_q;
    logic [SLOT_SPAN-1:0]      full_d;
    logic                      err_q;
    logic                      err_d;

    logic                      en_q;
    logic [KSK_RAM_ADD_W-1:0]  add_q;
    logic                      shift_q;
    logic                      avail_q;

    logic                      issue;
    logic                      last_line;
    logic                      last_pass;
    logic [KSK_RAM_ADD_W-1:0]  rd_addr;
    logic                      fill_ok;
    logic                      rel_same;

    node_cmd_t                 cmd0;
    node_cmd_t                 cut_cmd [KSK_CUT_NB];

    assign issue     = (state_q == ST_RUN) && buf_avail;
    assign last_line = (line_q == LINE_LAST);
    assign last_pass = ((pass_q + PASS_ONE) == pass_nb_q);
    assign rd_addr   = base_q + KSK_RAM_ADD_W'(line_q);

    assign rd_req_rdy = (state_q == ST_IDLE) && full_q[rd_req_slot];

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            pass_nb_q <= '0;
            pass_q    <= '0;
            line_q    <= '0;
            base_q    <= '0;
            free_q    <= 1'b0;
        end else begin
            free_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rd_req_vld && rd_req_rdy) begin
                        slot_q    <= rd_req_slot;
                        pass_nb_q <= {1'b0, rd_req_pass} + PASS_ONE;
                        pass_q    <= '0;
                        line_q    <= '0;
                        base_q    <= KSK_RAM_ADD_W'(rd_req_slot) * DEPTH_A;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        if (last_line) begin
                            line_q <= '0;
                            pass_q <= pass_q + PASS_ONE;
                            if (last_pass) begin
                                state_q <= ST_RELEASE;
                                free_q  <= 1'b1;
                            end
                        end else begin
                            line_q <= line_q + LINE_ONE;
                        end
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign slot_free_vld = free_q;
    assign slot_free_id  = slot_q;

    // A refill landing on the slot being released wins over the release.
    assign fill_ok  = fill_done_vld && ({1'b0, fill_done_id} < SLOT_LIM);
    assign rel_same = (state_q == ST_RELEASE) && fill_ok &&
                      (fill_done_id == slot_q);

    always_comb begin
        full_d = full_q;
        err_d  = 1'b0;
        if ((state_q == ST_RELEASE) && !rel_same) begin
            full_d[slot_q] = 1'b0;
        end
        if (fill_ok) begin
            if (!full_q[fill_done_id]) begin
                full_d[fill_done_id] = 1'b1;
            end else if (!rel_same) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            full_q <= '0;
            err_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            err_q  <= err_d;
        end
    end

    assign slot_full  = full_q[KSK_SLOT_NB-1:0];
    assign err_refill = err_q;

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            en_q    <= 1'b0;
            add_q   <= '0;
            shift_q <= 1'b0;
            avail_q <= 1'b0;
        end else begin
            en_q    <= issue;
            add_q   <= issue ? rd_addr : '0;
            shift_q <= issue;
            avail_q <= en_q;
        end
    end

    assign cmd0 = '{
        buf_in_avail: avail_q,
        buf_shift:    shift_q,
        ram_rd_addD:  add_q,
        ram_rd_enD:   en_q
    };

    ksk_mgr_cmd_skew #(
        .KSK_CUT_NB (KSK_CUT_NB),
        .node_cmd_t (node_cmd_t)
    ) u_skew (
        .clk     (clk),
        .s_rst_n (s_rst_n),
        .cmd_in  (cmd0),
        .cmd_out (cut_cmd)
    );

    for (genvar k = 0; k < KSK_CUT_NB; k++) begin : g_cut
        assign node_cmd[k*NODE_CMD_W +: NODE_CMD_W] = cut_cmd[k];
    end

endmodule

// File: tb/tb_ksk_mgr_rd_cmd_gen.sv
// Bench for ksk_mgr_rd_cmd_gen: queue-of-addresses reference model,
// per-cycle compare, directed scenarios and a random phase.
module tb_ksk_mgr_rd_cmd_gen;

    localparam int NB    = 4;
    localparam int DEPTH = 32;
    localparam int CUT   = 4;
    localparam int PW    = 4;
    localparam int SW    = 2;
    localparam int AW    = 7;
    localparam int CW    = AW + 3;
    localparam int H     = 16384;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_REL  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fill_done_vld = 1'b0;
    logic [SW-1:0]     fill_done_id = '0;
    logic              rd_req_vld = 1'b0;
    logic              rd_req_rdy;
    logic [SW-1:0]     rd_req_slot = '0;
    logic [PW-1:0]     rd_req_pass = '0;
    logic              buf_avail = 1'b0;
    logic [CUT*CW-1:0] node_cmd;
    logic              slot_free_vld;
    logic [SW-1:0]     slot_free_id;
    logic [NB-1:0]     slot_full;
    logic              err_refill;

    ksk_mgr_rd_cmd_gen #(
        .KSK_SLOT_NB    (NB),
        .KSK_SLOT_DEPTH (DEPTH),
        .KSK_CUT_NB     (CUT),
        .PASS_W         (PW)
    ) dut (
        .clk           (clk),
        .s_rst_n       (rst_n),
        .fill_done_vld (fill_done_vld),
        .fill_done_id  (fill_done_id),
        .rd_req_vld    (rd_req_vld),
        .rd_req_rdy    (rd_req_rdy),
        .rd_req_slot   (rd_req_slot),
        .rd_req_pass   (rd_req_pass),
        .buf_avail     (buf_avail),
        .node_cmd      (node_cmd),
        .slot_free_vld (slot_free_vld),
        .slot_free_id  (slot_free_id),
        .slot_full     (slot_full),
        .err_refill    (err_refill)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference model: a request becomes a list of addresses to emit.
    int            n = 0;
    bit            iss_h [H];
    int            adr_h [H];
    logic [NB-1:0] m_full = '0;
    int            m_mode = M_IDLE;
    int            m_slot = 0;
    bit            m_err = 1'b0;
    int            m_q [$];

    always @(posedge clk or negedge rst_n) begin
        bit iss;
        bit acc;
        bit same;
        if (!rst_n) begin
            for (int i = 0; i < H; i++) begin
                iss_h[i] = 1'b0;
                adr_h[i] = 0;
            end
            n      = 0;
            m_full = '0;
            m_mode = M_IDLE;
            m_slot = 0;
            m_err  = 1'b0;
            m_q.delete();
        end else begin
            iss = (m_mode == M_RUN) && buf_avail;
            iss_h[n % H] = iss;
            adr_h[n % H] = iss ? m_q[0] : 0;
            acc = (m_mode == M_IDLE) && rd_req_vld &&
                  (int'(rd_req_slot) < NB) && m_full[rd_req_slot];
            same = (m_mode == M_REL) && fill_done_vld &&
                   (int'(fill_done_id) == m_slot);
            m_err = 1'b0;
            if (fill_done_vld && int'(fill_done_id) < NB && !same) begin
                if (m_full[fill_done_id]) m_err = 1'b1;
                else m_full[fill_done_id] = 1'b1;
            end
            if (m_mode == M_REL) begin
                if (!same) m_full[m_slot] = 1'b0;
                m_mode = M_IDLE;
            end else if (acc) begin
                m_slot = int'(rd_req_slot);
                for (int p = 0; p <= int'(rd_req_pass); p++)
                    for (int l = 0; l < DEPTH; l++)
                        m_q.push_back(m_slot * DEPTH + l);
                m_mode = M_RUN;
            end
            if (iss) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_mode = M_REL;
            end
            n++;
        end
    end

    int obs [$];
    int free_cnt = 0;
    int last_free_id = -1;
    int err_cnt = 0;

    always @(negedge clk) begin
        logic [CW-1:0] e;
        bit en;
        bit av;
        int i1;
        int i2;
        bit rdy_e;
        for (int k = 0; k < CUT; k++) begin
            i1 = n - 1 - k;
            i2 = n - 2 - k;
            en = (i1 >= 0) && iss_h[i1 % H];
            av = (i2 >= 0) && iss_h[i2 % H];
            e  = {av, en, (en ? AW'(adr_h[i1 % H]) : AW'(0)), en};
            chk($sformatf("cmd_cut%0d", k), node_cmd[k*CW +: CW], e);
        end
        rdy_e = (m_mode == M_IDLE) && m_full[rd_req_slot];
        chk("rdy", rd_req_rdy, rdy_e);
        chk("free_vld", slot_free_vld, m_mode == M_REL);
        if (m_mode == M_REL) chk("free_id", slot_free_id, m_slot);
        chk("err_refill", err_refill, m_err);
        chk("slot_full", slot_full, m_full);
        if (node_cmd[0]) obs.push_back(int'(node_cmd[AW:1]));
        if (slot_free_vld) begin
            free_cnt++;
            last_free_id = int'(slot_free_id);
        end
        if (err_refill) err_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int id);
        fill_done_vld = 1'b1;
        fill_done_id  = SW'(id);
        step();
        fill_done_vld = 1'b0;
    endtask

    task automatic request(input int slot, input int pass, output bit ok);
        rd_req_vld  = 1'b1;
        rd_req_slot = SW'(slot);
        rd_req_pass = PW'(pass);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = rd_req_rdy;
            step();
        end
        rd_req_vld = 1'b0;
    endtask

    task automatic wait_free(input int bound, input bit toggle);
        int c0;
        int i;
        c0 = free_cnt;
        i  = 0;
        while (free_cnt == c0 && i < bound) begin
            if (toggle) buf_avail = ~buf_avail;
            step();
            i++;
        end
        chk("free_seen", free_cnt - c0, 1);
    endtask

    function automatic int seq_bad(input int first, input int wrap);
        int bad = 0;
        foreach (obs[i]) if (obs[i] != first + (i % wrap)) bad++;
        return bad;
    endfunction

    function automatic int obs_at(input int i);
        return (i < obs.size()) ? obs[i] : -1;
    endfunction

    initial begin
        bit ok;
        bit seen;
        int e0;
        int f0;

        step();
        @(negedge clk);
        chk("rst_cmd", node_cmd, 0);
        chk("rst_full", slot_full, 0);
        chk("rst_rdy", rd_req_rdy, 0);
        step();
        rst_n = 1'b1;
        step();

        // one pass over slot 1
        buf_avail = 1'b1;
        fill(1);
        obs.delete();
        request(1, 0, ok);
        chk("a_acc", ok, 1);
        wait_free(200, 1'b0);
        repeat (3) step();
        chk("a_cnt", obs.size(), 32);
        chk("a_first", obs_at(0), 32);
        chk("a_last", obs_at(31), 63);
        chk("a_seq", seq_bad(32, 32), 0);
        chk("a_free_id", last_free_id, 1);
        chk("a_full1", slot_full[1], 0);

        // request waits on an empty slot
        obs.delete();
        rd_req_vld  = 1'b1;
        rd_req_slot = 2'd2;
        rd_req_pass = '0;
        repeat (4) begin
            @(negedge clk);
            chk("b_rdy0", rd_req_rdy, 0);
            step();
        end
        fill_done_vld = 1'b1;
        fill_done_id  = 2'd2;
        step();
        fill_done_vld = 1'b0;
        @(negedge clk);
        chk("b_rdy1", rd_req_rdy, 1);
        step();
        rd_req_vld = 1'b0;
        wait_free(200, 1'b0);
        repeat (3) step();
        chk("b_cnt", obs.size(), 32);
        chk("b_first", obs_at(0), 64);
        chk("b_seq", seq_bad(64, 32), 0);

        // three passes with stalling buffers
        fill(0);
        obs.delete();
        request(0, 2, ok);
        chk("c_acc", ok, 1);
        wait_free(1000, 1'b1);
        buf_avail = 1'b1;
        repeat (3) step();
        chk("c_cnt", obs.size(), 96);
        chk("c_seq", seq_bad(0, 32), 0);

        // refill errors and refill racing the release
        fill(0);
        e0 = err_cnt;
        fill(0);
        step();
        chk("d_err", err_cnt - e0, 1);
        chk("d_full0", slot_full[0], 1);
        fill(3);
        request(3, 0, ok);
        e0 = err_cnt;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = slot_free_vld;
        end
        chk("d_rel_seen", seen, 1);
        if (seen) begin
            fill_done_vld = 1'b1;
            fill_done_id  = 2'd3;
            step();
            fill_done_vld = 1'b0;
            @(negedge clk);
            chk("d_keep3", slot_full[3], 1);
            chk("d_noerr", err_cnt - e0, 0);
        end
        step();

        // reset in the middle of a run at line 10
        fill(1);
        request(1, 0, ok);
        chk("e_acc", ok, 1);
        repeat (10) step();
        f0 = free_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk("e_cmd0", node_cmd, 0);
        chk("e_full0", slot_full, 0);
        chk("e_free0", slot_free_vld, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("e_nofree", free_cnt - f0, 0);
        fill(1);
        request(1, 0, ok);
        chk("e_reacc", ok, 1);
        wait_free(200, 1'b0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            fill_done_vld = ($urandom_range(0, 7) == 0);
            fill_done_id  = SW'($urandom_range(0, NB - 1));
            buf_avail     = ($urandom_range(0, 3) != 0);
            if (!rd_req_vld || $urandom_range(0, 15) == 0) begin
                rd_req_vld  = $urandom_range(0, 1) == 1;
                rd_req_slot = SW'($urandom_range(0, NB - 1));
                rd_req_pass = PW'($urandom_range(0, 1));
            end
            step();
        end
        fill_done_vld = 1'b0;
        rd_req_vld    = 1'b0;
        buf_avail     = 1'b1;
        repeat (100) step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
